// File: rtl/button_conditioner_if.sv
// Button bus between the pin side and the conditioner: raw pins in,
// debounced level and one-cycle press/release pulses out.
interface button_conditioner_if #(
    parameter int N_BTN = 2
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;

    // Pin side: drives the raw buttons, consumes conditioned events.
    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release
    );

    // Conditioner side.
    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release
    );
endinterface

// File: rtl/button_conditioner.sv
// button_conditioner: per-channel synchronizer, polarity normalisation,
// debounce FSM and registered press/release pulses.
// Optional feature: define BTN_AUTOREPEAT_EN to add auto-repeat press pulses
// while a button is held (REPEAT_DELAY first, then every REPEAT_RATE cycles).
// Without the macro the repeat timer is not built at all.
module button_conditioner #(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic                 clk,
    input  logic                 rst,
    button_conditioner_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    // Raw pin value that means "not pressed"; synchronizers reset to it so
    // no phantom press is seen coming out of reset.
    localparam logic RAW_RELEASED = (ACTIVE_LOW != 0);

    // Stability counter holds at most DEBOUNCE_CYCLES-1 before the
    // accepting edge, so it is sized for DEBOUNCE_CYCLES.
    localparam int              STAB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_RATE_LAST  = RPT_W'(REPEAT_RATE - 1);
`endif

    // Reject illegal timing parameters at elaboration.
    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
        $error("button_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_RATE must be >= 1");
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic              sync1_q;
        logic              sync2_q;
        logic              pressed;
        state_t            state_q;
        logic [STAB_W-1:0] stab_q;
        logic              level_q;
        logic              press_q;
        logic              release_q;
`ifdef BTN_AUTOREPEAT_EN
        logic [RPT_W-1:0]  rpt_q;
        logic              rpt_first_q;
        logic [RPT_W-1:0]  rpt_last;

        // First repeat waits REPEAT_DELAY, later ones REPEAT_RATE.
        assign rpt_last = rpt_first_q ? RPT_DELAY_LAST : RPT_RATE_LAST;
`endif

        // Two-flop synchronizer for the asynchronous pin.
        always_ff @(posedge clk) begin
            // NOTE: non-blocking assignments give a true two-stage shift;
            // blocking ones would collapse both flops into one.
            if (rst) begin
                sync1_q <= RAW_RELEASED;
                sync2_q <= RAW_RELEASED;
            end else begin
                sync1_q <= bus.btn_raw[i];
                sync2_q <= sync1_q;
            end
        end

        // Normalise polarity: 1 means pressed from here on.
        assign pressed = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

        // Debounce FSM with registered level and pulse outputs.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q     <= IDLE;
                stab_q      <= '0;
                level_q     <= 1'b0;
                press_q     <= 1'b0;
                release_q   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
                rpt_q       <= '0;
                rpt_first_q <= 1'b1;
`endif
            end else begin
                // NOTE: pulses default low every cycle so a branch that
                // asserts one produces exactly a single-cycle pulse.
                press_q   <= 1'b0;
                release_q <= 1'b0;
                case (state_q)
                    IDLE: begin
                        stab_q <= '0;
`ifdef BTN_AUTOREPEAT_EN
                        rpt_q       <= '0;
                        rpt_first_q <= 1'b1;
`endif
                        if (pressed) begin
                            state_q <= PRESS_WAIT;
                        end
                    end

                    PRESS_WAIT: begin
                        if (pressed == level_q) begin
                            // Bounced back: throw the partial count away.
                            stab_q  <= '0;
                            state_q <= IDLE;
                        end else if (stab_q >= STAB_LAST) begin
                            stab_q  <= '0;
                            state_q <= HELD;
                            level_q <= 1'b1;
                            press_q <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                            rpt_q       <= '0;
                            rpt_first_q <= 1'b1;
`endif
                        end else begin
                            stab_q <= stab_q + 1'b1;
                        end
                    end

                    HELD: begin
                        stab_q <= '0;
                        if (!pressed) begin
                            // Repeat timer freezes here until we know
                            // whether this is a real release or a bounce.
                            state_q <= RELEASE_WAIT;
                        end
`ifdef BTN_AUTOREPEAT_EN
                        else if (rpt_q >= rpt_last) begin
                            rpt_q       <= '0;
                            rpt_first_q <= 1'b0;
                            press_q     <= 1'b1;
                        end else begin
                            // Bounded by rpt_last, so it can never wrap.
                            rpt_q <= rpt_q + 1'b1;
                        end
`endif
                    end

                    RELEASE_WAIT: begin
                        if (pressed == level_q) begin
                            // Bounce: resume HELD with the repeat timer intact.
                            stab_q  <= '0;
                            state_q <= HELD;
                        end else if (stab_q >= STAB_LAST) begin
                            stab_q    <= '0;
                            state_q   <= IDLE;
                            level_q   <= 1'b0;
                            release_q <= 1'b1;
                        end else begin
                            stab_q <= stab_q + 1'b1;
                        end
                    end

                    default: begin
                        state_q <= IDLE;
                        stab_q  <= '0;
                    end
                endcase
            end
        end

        assign bus.btn_level[i]   = level_q;
        assign bus.btn_press[i]   = press_q;
        assign bus.btn_release[i] = release_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with N_BTN=2, DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_RATE=3, ACTIVE_LOW=1. Honours BTN_AUTOREPEAT_EN.
module tb_button_conditioner;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RR = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    button_conditioner_if #(.N_BTN(2)) bus ();

    button_conditioner #(
        .N_BTN          (2),
        .DEBOUNCE_CYCLES(D),
        .ACTIVE_LOW     (1),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: debounced level follows a channel once its synced
    // value has disagreed with the level for D+1 consecutive edges; repeats
    // are scheduled from the number of settled held edges since the press.
    logic [1:0] pipe0, pipe1;          // raw pin history (2 edges)
    logic [1:0] m_level, m_press, m_rel;
    int         run [2];
    int         hold [2];

    task automatic model_edge();
        logic s;
        if (rst) begin
            pipe0   = 2'b11;
            pipe1   = 2'b11;
            m_level = 2'b00;
            m_press = 2'b00;
            m_rel   = 2'b00;
            for (int c = 0; c < 2; c++) begin
                run[c]  = 0;
                hold[c] = 0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                s = ~pipe1[c];
                m_press[c] = 1'b0;
                m_rel[c]   = 1'b0;
                if (s != m_level[c]) begin
                    run[c]++;
                    if (run[c] == D + 1) begin
                        run[c]     = 0;
                        m_level[c] = s;
                        if (s) begin
                            m_press[c] = 1'b1;
                            hold[c]    = 0;
                        end else begin
                            m_rel[c] = 1'b1;
                        end
                    end
                end else begin
`ifdef BTN_AUTOREPEAT_EN
                    if (m_level[c] && run[c] == 0) begin
                        hold[c]++;
                        if (hold[c] >= RD && ((hold[c] - RD) % RR) == 0)
                            m_press[c] = 1'b1;
                    end
`endif
                    run[c] = 0;
                end
            end
            pipe1 = pipe0;
            pipe0 = bus.btn_raw;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: model the edge, then compare all outputs just after it.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("level",   32'(bus.btn_level),   32'(m_level));
        check("press",   32'(bus.btn_press),   32'(m_press));
        check("release", 32'(bus.btn_release), 32'(m_rel));
        check("press_and_release", 32'(bus.btn_press & bus.btn_release), 32'd0);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Step until a masked pulse appears; k = step index (0 = first edge) or -1.
    task automatic wait_pulse(input bit rel, input logic [1:0] mask,
                              output int k, output logic [1:0] seen);
        logic [1:0] v;
        k    = -1;
        seen = 2'b00;
        for (int i = 0; i < 40; i++) begin
            step();
            v = rel ? bus.btn_release : bus.btn_press;
            if ((v & mask) != 2'b00) begin
                k    = i;
                seen = v;
                break;
            end
        end
    endtask

    int         k;
    logic [1:0] seen;
    logic [30:0] rmask, rexp;
    logic       flag;

    initial begin
        bus.btn_raw = 2'b11;
        rst = 1'b1;
        pipe0 = 2'b11; pipe1 = 2'b11;
        m_level = '0; m_press = '0; m_rel = '0;
        for (int c = 0; c < 2; c++) begin run[c] = 0; hold[c] = 0; end

        // Reset state.
        steps(3);
        check("reset_level", 32'(bus.btn_level), 32'd0);
        check("reset_press", 32'(bus.btn_press), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        steps(4);

        // Clean press on channel 0, then hold 30 cycles for auto-repeat.
        bus.btn_raw = 2'b10;
        wait_pulse(1'b0, 2'b01, k, seen);
        check("clean_press_latency", 32'(k), 32'd6);
        check("clean_level_set", 32'(bus.btn_level[0]), 32'd1);
        rmask = '0;
        rmask[0] = (k >= 0);
        for (int r = 1; r <= 30; r++) begin
            step();
            if (bus.btn_press[0]) rmask[r] = 1'b1;
        end
        rexp = '0;
        rexp[0] = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
        for (int r = RD; r <= 30; r += RR) rexp[r] = 1'b1;
`endif
        check("repeat_pattern", 32'(rmask), 32'(rexp));

        // Clean release latency.
        bus.btn_raw = 2'b11;
        wait_pulse(1'b1, 2'b01, k, seen);
        check("release_latency", 32'(k), 32'd6);
        check("release_level", 32'(bus.btn_level[0]), 32'd0);
        steps(4);

        // Bounce: low 3, high 1, then low steady.
        flag = 1'b0;
        bus.btn_raw = 2'b10;
        for (int i = 0; i < 3; i++) begin step(); flag |= bus.btn_press[0]; end
        bus.btn_raw = 2'b11;
        step(); flag |= bus.btn_press[0];
        bus.btn_raw = 2'b10;
        wait_pulse(1'b0, 2'b01, k, seen);
        check("bounce_no_early_pulse", 32'(flag), 32'd0);
        check("bounce_latency", 32'(k), 32'd6);
        bus.btn_raw = 2'b11;
        steps(12);

        // Simultaneous press and release on both channels.
        bus.btn_raw = 2'b00;
        wait_pulse(1'b0, 2'b11, k, seen);
        check("simul_press", 32'(seen), 32'b11);
        steps(3);
        bus.btn_raw = 2'b11;
        wait_pulse(1'b1, 2'b11, k, seen);
        check("simul_release", 32'(seen), 32'b11);
        steps(4);

        // Release glitch on channel 1 while held.
        bus.btn_raw = 2'b01;
        wait_pulse(1'b0, 2'b10, k, seen);
        check("glitch_press_seen", 32'(k), 32'd6);
        bus.btn_raw = 2'b11;
        steps(2);
        bus.btn_raw = 2'b01;
        flag = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            flag |= bus.btn_release[1] | ~bus.btn_level[1];
        end
        check("glitch_no_release", 32'(flag), 32'd0);
        bus.btn_raw = 2'b11;
        steps(12);

        // Reset mid-hold on channel 0, button stays pressed.
        bus.btn_raw = 2'b10;
        wait_pulse(1'b0, 2'b01, k, seen);
        steps(2);
        rst = 1'b1;
        step();
        check("rst_level", 32'(bus.btn_level), 32'd0);
        check("rst_press", 32'(bus.btn_press | bus.btn_release), 32'd0);
        step();
        rst = 1'b0;
        wait_pulse(1'b0, 2'b01, k, seen);
        check("rst_refire_latency", 32'(k), 32'd6);
        bus.btn_raw = 2'b11;
        steps(12);

        // Randomized bouncing on both channels against the model.
        for (int seg = 0; seg < 300; seg++) begin
            bus.btn_raw = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) rst = 1'b1;
            steps(1);
            rst = 1'b0;
            steps($urandom_range(0, 15));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
